// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq
// -----------------
// Scanline IRQ generator for the MMC3-family mappers in the multicart.
// PPU A12 is synchronised into the m2 domain and filtered so that short
// A12 low glitches do not count. A rising edge that follows a long enough
// low period clocks an 8-bit reloadable down-counter. When that counter
// lands on zero while IRQs are enabled, the sticky pending flag is set and
// the active-low cartridge irq line is driven.
//
// Parameters
//   FILTER_CYCLES  consecutive low m2 cycles of synchronised A12 needed
//                  before a rising edge counts (legal 1..15)
//
// Ports
//   m2        CPU M2, the only clock
//   reset     synchronous active-high reset
//   reg_wr    one-cycle register write strobe from the mapper decoder
//   reg_sel   0 latch, 1 reload, 2 disable/ack, 3 enable
//   reg_data  latch value (used for reg_sel 0 only)
//   ppu_a12   raw PPU A12, asynchronous to m2
//   irq       registered active-low IRQ request
//   counter   current counter value for debug readback
//   pending   IRQ pending flag (always the inverse of irq)
//
// Build option
//   MMC3_IRQ_OLD_BEHAVIOUR_EN  when defined, selects MMC3A-style IRQ
//   generation: a counter that was already zero and is reloaded with zero
//   without a reload write does not raise the IRQ.

module mmc3_scanline_irq #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic       m2,
  input  logic       reset,
  input  logic       reg_wr,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_data,
  input  logic       ppu_a12,
  output logic       irq,
  output logic [7:0] counter,
  output logic       pending
);

  localparam logic [3:0] FILTER_MAX = 4'(FILTER_CYCLES);

  typedef enum logic [1:0] {
    SEL_LATCH   = 2'd0,
    SEL_RELOAD  = 2'd1,
    SEL_DISABLE = 2'd2,
    SEL_ENABLE  = 2'd3
  } sel_e;

  logic       s1, s2, s3;
  logic [3:0] low_cnt;
  logic [7:0] latch;
  logic       reload;
  logic       enable;

  logic       clk_ev;
  logic       wr_reload;
  logic       ev_taken;
  logic [7:0] ev_next;
  logic       ev_fire;

  logic [7:0] latch_n;
  logic [7:0] counter_n;
  logic       reload_n;
  logic       enable_n;
  logic       pending_n;

  // Bring A12 into the m2 domain and measure how long it has been low.
  // The low counter saturates at the filter length so it never wraps and
  // a long low period still qualifies the next rising edge.
  always_ff @(posedge m2) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      low_cnt <= 4'd0;
    end else begin
      s1 <= ppu_a12;
      s2 <= s1;
      s3 <= s2;
      if (s2) begin
        low_cnt <= 4'd0;
      end else if (low_cnt < FILTER_MAX) begin
        low_cnt <= low_cnt + 4'd1;
      end
    end
  end

  // A qualified rising edge uses the low count from before this cycle's
  // update, so the low period ending in the previous cycle is what counts.
  // A reload write in the same cycle swallows the clock event entirely.
  assign clk_ev    = s2 & ~s3 & (low_cnt >= FILTER_MAX);
  assign wr_reload = reg_wr && (sel_e'(reg_sel) == SEL_RELOAD);
  assign ev_taken  = clk_ev && !wr_reload;
  assign ev_next   = ((counter == 8'd0) || reload) ? latch : counter - 8'd1;

  // The IRQ decision always sees the enable state from before any write in
  // this cycle. The older chips additionally refuse to fire when a counter
  // that was already zero is simply refilled with zero.
`ifdef MMC3_IRQ_OLD_BEHAVIOUR_EN
  assign ev_fire = ev_taken && enable && (ev_next == 8'd0) &&
                   ((counter != 8'd0) || reload);
`else
  assign ev_fire = ev_taken && enable && (ev_next == 8'd0);
`endif

  // Next-state for the counter block. Clock event effects are applied
  // first and register writes afterwards, so a write overrides whatever
  // the event did to the same register (ack clears a just-set pending,
  // a reload write zeroes the counter). The latch is only read by the
  // event path, so a same-cycle latch write affects later events only.
  always_comb begin
    latch_n   = latch;
    counter_n = counter;
    reload_n  = reload;
    enable_n  = enable;
    pending_n = pending;

    if (ev_taken) begin
      counter_n = ev_next;
      if ((counter == 8'd0) || reload) begin
        reload_n = 1'b0;
      end
      if (ev_fire) begin
        pending_n = 1'b1;
      end
    end

    if (reg_wr) begin
      case (sel_e'(reg_sel))
        SEL_LATCH: begin
          latch_n = reg_data;
        end
        SEL_RELOAD: begin
          counter_n = 8'd0;
          reload_n  = 1'b1;
        end
        SEL_DISABLE: begin
          enable_n  = 1'b0;
          pending_n = 1'b0;
        end
        SEL_ENABLE: begin
          enable_n = 1'b1;
        end
        default: begin
          enable_n = enable;
        end
      endcase
    end
  end

  // Counter block state. irq is kept as its own flop, loaded with the
  // inverse of the next pending value, so the CPU sees a glitch-free line.
  always_ff @(posedge m2) begin
    if (reset) begin
      latch   <= 8'd0;
      counter <= 8'd0;
      reload  <= 1'b0;
      enable  <= 1'b0;
      pending <= 1'b0;
      irq     <= 1'b1;
    end else begin
      latch   <= latch_n;
      counter <= counter_n;
      reload  <= reload_n;
      enable  <= enable_n;
      pending <= pending_n;
      irq     <= ~pending_n;
    end
  end

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// tb_mmc3_scanline_irq
// --------------------
// Self-checking bench for mmc3_scanline_irq. Each scenario task pushes the
// counter/irq values it expects onto a scoreboard queue as it drives the
// stimulus, then pops and compares once the DUT has produced the result.

module tb_mmc3_scanline_irq;

  localparam int FILTER_CYCLES = 3;

`ifdef MMC3_IRQ_OLD_BEHAVIOUR_EN
  localparam bit OLD_BEHAVIOUR = 1'b1;
`else
  localparam bit OLD_BEHAVIOUR = 1'b0;
`endif

  logic       m2 = 1'b0;
  logic       reset;
  logic       reg_wr;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       ppu_a12;
  logic       irq;
  logic [7:0] counter;
  logic       pending;

  typedef struct packed {
    logic [7:0] counter;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  mmc3_scanline_irq #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .m2      (m2),
    .reset   (reset),
    .reg_wr  (reg_wr),
    .reg_sel (reg_sel),
    .reg_data(reg_data),
    .ppu_a12 (ppu_a12),
    .irq     (irq),
    .counter (counter),
    .pending (pending)
  );

  // Free-running m2, 10 time units per cycle.
  always #5 m2 = ~m2;

  // Advance one m2 cycle and land just after the rising edge, where inputs
  // are driven and outputs are sampled.
  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [7:0] data);
    reg_wr   = 1'b1;
    reg_sel  = sel;
    reg_data = data;
    tick();
    reg_wr   = 1'b0;
  endtask

  // A12 high for high_len cycles then low for low_len cycles. With
  // low_len >= 1 the counter update from this pulse is complete on return.
  task automatic pulse(input int high_len, input int low_len);
    ppu_a12 = 1'b1;
    repeat (high_len) tick();
    ppu_a12 = 1'b0;
    repeat (low_len) tick();
  endtask

  // A12 pulse whose clock event lands in the same cycle as a register
  // write; returns right after the edge that applies both.
  task automatic collide(input logic [1:0] sel, input logic [7:0] data);
    ppu_a12 = 1'b1;
    tick();
    tick();
    ppu_a12  = 1'b0;
    reg_wr   = 1'b1;
    reg_sel  = sel;
    reg_data = data;
    tick();
    reg_wr   = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    reg_wr   = 1'b0;
    reg_sel  = 2'd0;
    reg_data = 8'd0;
    ppu_a12  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sb.push_back('{counter: 8'd0, irq: 1'b1});
      tick();
      e = sb.pop_front();
      checks++;
      if (counter !== e.counter || irq !== e.irq || pending !== ~e.irq) begin
        errors++;
        $display("[TB] FAIL reset_idle[%0d]: got counter=%0d irq=%b pending=%b, want counter=%0d irq=%b",
                 i, counter, irq, pending, e.counter, e.irq);
      end
    end
  endtask

  task automatic test_count();
    write_reg(2'd0, 8'd3);
    write_reg(2'd1, 8'd0);
    write_reg(2'd3, 8'd0);
    sb.push_back('{counter: 8'd3, irq: 1'b1});
    sb.push_back('{counter: 8'd2, irq: 1'b1});
    sb.push_back('{counter: 8'd1, irq: 1'b1});
    sb.push_back('{counter: 8'd1, irq: 1'b1});
    sb.push_back('{counter: 8'd0, irq: 1'b0});
    sb.push_back('{counter: 8'd0, irq: 1'b0});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    sb.push_back('{counter: 8'd3, irq: 1'b1});
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1, 2: pulse(2, 8);
        3: begin ppu_a12 = 1'b1; tick(); tick(); end
        4: begin ppu_a12 = 1'b0; tick(); end
        5: repeat (7) tick();
        6: write_reg(2'd2, 8'd0);
        default: pulse(2, 8);
      endcase
      e = sb.pop_front();
      checks++;
      if (counter !== e.counter || irq !== e.irq || pending !== ~e.irq) begin
        errors++;
        $display("[TB] FAIL count[%0d]: got counter=%0d irq=%b pending=%b, want counter=%0d irq=%b",
                 i, counter, irq, pending, e.counter, e.irq);
      end
    end
  endtask

  task automatic test_glitch_filter();
    int lows[5] = '{8, 2, 3, 8, 8};
    logic [7:0] want[5] = '{8'd10, 8'd9, 8'd9, 8'd8, 8'd7};
    write_reg(2'd0, 8'd10);
    write_reg(2'd1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{counter: want[i], irq: 1'b1});
      pulse(2, lows[i]);
      e = sb.pop_front();
      checks++;
      if (counter !== e.counter || irq !== e.irq || pending !== ~e.irq) begin
        errors++;
        $display("[TB] FAIL glitch[%0d]: got counter=%0d irq=%b pending=%b, want counter=%0d irq=%b",
                 i, counter, irq, pending, e.counter, e.irq);
      end
    end
  endtask

  task automatic test_latch_zero();
    write_reg(2'd0, 8'd0);
    write_reg(2'd1, 8'd0);
    write_reg(2'd3, 8'd0);
    sb.push_back('{counter: 8'd0, irq: 1'b0});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    sb.push_back('{counter: 8'd0, irq: OLD_BEHAVIOUR ? 1'b1 : 1'b0});
    sb.push_back('{counter: 8'd0, irq: OLD_BEHAVIOUR ? 1'b1 : 1'b0});
    sb.push_back('{counter: 8'd0, irq: 1'b0});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: pulse(2, 8);
        1: write_reg(2'd2, 8'd0);
        2: begin write_reg(2'd3, 8'd0); pulse(2, 8); end
        3: begin write_reg(2'd2, 8'd0); write_reg(2'd3, 8'd0); pulse(2, 8); end
        4: begin write_reg(2'd1, 8'd0); pulse(2, 8); end
        default: write_reg(2'd2, 8'd0);
      endcase
      e = sb.pop_front();
      checks++;
      if (counter !== e.counter || irq !== e.irq || pending !== ~e.irq) begin
        errors++;
        $display("[TB] FAIL latch_zero[%0d]: got counter=%0d irq=%b pending=%b, want counter=%0d irq=%b",
                 i, counter, irq, pending, e.counter, e.irq);
      end
    end
  endtask

  task automatic test_back_to_back();
    write_reg(2'd0, 8'd5);
    write_reg(2'd1, 8'd0);
    sb.push_back('{counter: 8'd5, irq: 1'b1});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    sb.push_back('{counter: 8'd9, irq: 1'b1});
    sb.push_back('{counter: 8'd9, irq: 1'b1});
    sb.push_back('{counter: 8'd8, irq: 1'b1});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: pulse(2, 8);
        1: begin write_reg(2'd0, 8'd9); collide(2'd1, 8'd0); end
        2: begin repeat (7) tick(); pulse(2, 8); end
        3: begin write_reg(2'd1, 8'd0); collide(2'd0, 8'd20); end
        4: begin repeat (7) tick(); pulse(2, 8); end
        5: begin write_reg(2'd0, 8'd0); write_reg(2'd1, 8'd0); collide(2'd3, 8'd0); end
        6: begin repeat (7) tick(); write_reg(2'd1, 8'd0); collide(2'd2, 8'd0); end
        default: begin repeat (7) tick(); write_reg(2'd1, 8'd0); pulse(2, 8); end
      endcase
      e = sb.pop_front();
      checks++;
      if (counter !== e.counter || irq !== e.irq || pending !== ~e.irq) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got counter=%0d irq=%b pending=%b, want counter=%0d irq=%b",
                 i, counter, irq, pending, e.counter, e.irq);
      end
    end
  endtask

  task automatic test_reset_mid();
    write_reg(2'd0, 8'd0);
    write_reg(2'd1, 8'd0);
    write_reg(2'd3, 8'd0);
    sb.push_back('{counter: 8'd0, irq: 1'b0});
    sb.push_back('{counter: 8'd7, irq: 1'b0});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    sb.push_back('{counter: 8'd0, irq: 1'b1});
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: pulse(2, 8);
        1: begin write_reg(2'd0, 8'd7); write_reg(2'd1, 8'd0); pulse(2, 8); end
        2: begin reset = 1'b1; tick(); reset = 1'b0; end
        default: begin repeat (8) tick(); pulse(2, 8); end
      endcase
      e = sb.pop_front();
      checks++;
      if (counter !== e.counter || irq !== e.irq || pending !== ~e.irq) begin
        errors++;
        $display("[TB] FAIL reset_mid[%0d]: got counter=%0d irq=%b pending=%b, want counter=%0d irq=%b",
                 i, counter, irq, pending, e.counter, e.irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_glitch_filter();
    test_latch_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
